// File: rtl/timer_pkg.sv
// timer_pkg: shared types and command encodings for the interval timer.
// Imported by interval_timer_ctrl and timer_prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  // A START from these states loads fresh config.
  function automatic logic can_load(state_e s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: down-counter that emits a one-cycle enable every
// load_i+1 advancing cycles; clr_i restarts the phase, hold_i freezes it.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  hold_i,
  input  logic [PRESCALE_W-1:0] load_i,
  output logic                  en_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  // Enable fires when the phase counter has run down.
  assign en_o = !clr_i && !hold_i && (cnt_q == '0);

  // Next phase: reload on clear or on wrap, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = load_i;
    end else if (!hold_i) begin
      if (cnt_q == '0) begin
        cnt_d = load_i;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: command-driven interval timer, one-shot or periodic.
// Define TIMER_PRESCALER_EN to build the enable prescaler.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      period,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tick,
  output logic                  done
);

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   count_d;
  logic [WIDTH-1:0]   period_q;
  logic [WIDTH-1:0]   period_d;
  logic               periodic_q;
  logic               periodic_d;
  logic               tick_q;
  logic               tick_d;
  logic               busy_q;
  logic               busy_d;
  logic               done_q;
  logic               done_d;
  logic               ready_q;
  logic               ready_d;

  logic               accept;
  logic               op_start;
  logic               op_stop;
  logic               op_clear;
  logic               fresh_start;
  logic               run_adv;
  logic               at_term;
  logic               en;

  assign accept  = cmd_valid && ready_q;
  assign at_term = (count_q == period_q);

  // A RUN cycle advances time only if no command lands in it.
  assign run_adv = (state_q == RUN) && !accept;

  // Decode the accepted command into one-hot strobes.
  always_comb begin
    op_start = 1'b0;
    op_stop  = 1'b0;
    op_clear = 1'b0;
    if (accept) begin
      unique case (cmd_op)
        CMD_START: op_start = 1'b1;
        CMD_STOP:  op_stop  = 1'b1;
        CMD_CLEAR: op_clear = 1'b1;
        CMD_NOP:   ;
      endcase
    end
  end

  assign fresh_start = op_start && can_load(state_q);

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] prescale_d;

  // Divider reloads from the port on the start edge itself.
  assign prescale_d = fresh_start ? prescale : prescale_q;

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (fresh_start),
    .hold_i (!run_adv),
    .load_i (prescale_d),
    .en_o   (en)
  );

  // Latched divider value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end
`else
  logic prescale_unused;
  assign prescale_unused = ^prescale;
  assign en = run_adv;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: commands first, else terminal enable in one-shot.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      op_start: begin
        if (state_q != RUN) begin
          state_d = RUN;
        end
      end
      op_stop: begin
        if (state_q == RUN) begin
          state_d = PAUSE;
        end
      end
      op_clear: state_d = IDLE;
      default: begin
        if (en && at_term && !periodic_q) begin
          state_d = DONE;
        end
      end
    endcase
  end

  // Datapath and registered outputs derived from the transition.
  always_comb begin
    count_d    = count_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    ready_d    = !accept;
    busy_d     = (state_d == RUN);
    done_d     = (state_d == DONE);
    if (op_clear || fresh_start) begin
      count_d = '0;
    end
    if (fresh_start) begin
      period_d   = period;
      periodic_d = periodic;
    end
    if (en) begin
      if (at_term) begin
        tick_d = 1'b1;
        if (periodic_q) begin
          count_d = '0;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign tick      = tick_q;
  assign done      = done_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed scenarios plus randomized commands
// checked against an arithmetic reference model of the timer.
module tb_interval_timer_ctrl;
  import timer_pkg::*;

`ifdef TIMER_PRESCALER_EN
  localparam bit PS_ON = 1'b1;
`else
  localparam bit PS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] period = 8'd0;
  logic       periodic = 1'b0;
  logic [7:0] prescale = 8'd0;
  logic       cmd_ready;
  logic [7:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  int checks = 0;
  int failures = 0;

  interval_timer_ctrl #(
    .WIDTH      (8),
    .PRESCALE_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .period    (period),
    .periodic  (periodic),
    .prescale  (prescale),
    .count     (count),
    .busy      (busy),
    .tick      (tick),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: st 0=idle 1=run 2=pause 3=done.
  // Prescaler is a count of advancing RUN cycles modulo P+1.
  int m_st = 0;
  int m_cnt = 0;
  int m_t = 0;
  int m_p = 0;
  int m_ph = 0;
  bit m_per = 0;
  bit m_tick = 0;
  bit m_rdy = 0;
  bit m_acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_tick = 0; m_rdy = 0; m_ph = 0;
    end else begin
      m_acc = cmd_valid && m_rdy;
      m_tick = 0;
      if (m_acc) begin
        if (cmd_op == 2'd1) begin
          if (m_st == 0 || m_st == 3) begin
            m_st = 1; m_t = int'(period);
            m_p = PS_ON ? int'(prescale) : 0;
            m_per = periodic; m_cnt = 0; m_ph = 0;
          end else if (m_st == 2) begin
            m_st = 1;
          end
        end else if (cmd_op == 2'd2) begin
          if (m_st == 1) m_st = 2;
        end else if (cmd_op == 2'd3) begin
          m_st = 0; m_cnt = 0;
        end
      end else if (m_st == 1) begin
        m_ph++;
        if (m_ph == m_p + 1) begin
          m_ph = 0;
          if (m_cnt == m_t) begin
            m_tick = 1;
            if (m_per) m_cnt = 0;
            else m_st = 3;
          end else begin
            m_cnt++;
          end
        end
      end
      m_rdy = !m_acc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input int t,
                      input bit per, input int p);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: cmd_ready=%0b required=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    period    = t[7:0];
    periodic  = per;
    prescale  = p[7:0];
    step();
    cmd_valid = 1'b0;
    cmd_op    = CMD_NOP;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) step();
    checks++;
    if ({count, tick, done, busy, cmd_ready} !== 12'd0) begin
      failures++;
      $display("FAIL reset_held: count=%0d tick=%0b done=%0b busy=%0b rdy=%0b required all 0",
               count, tick, done, busy, cmd_ready);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({count, tick, done, busy, cmd_ready} !== 12'd1) begin
      failures++;
      $display("FAIL reset_release: count=%0d tick=%0b done=%0b busy=%0b rdy=%0b required rdy=1 rest 0",
               count, tick, done, busy, cmd_ready);
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] ec;
    send(CMD_START, 3, 1'b0, 0);
    checks++;
    if ({count, busy, cmd_ready} !== {8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_start: count=%0d busy=%0b rdy=%0b required 0 1 0",
               count, busy, cmd_ready);
    end
    for (int j = 1; j <= 6; j++) begin
      step();
      ec = (j < 3) ? 8'(j) : 8'd3;
      checks++;
      if ({count, tick, done, busy, cmd_ready} !==
          {ec, j == 4, j >= 4, j < 4, 1'b1}) begin
        failures++;
        $display("FAIL oneshot j=%0d: count=%0d tick=%0b done=%0b busy=%0b rdy=%0b required count=%0d tick=%0b done=%0b busy=%0b rdy=1",
                 j, count, tick, done, busy, cmd_ready, ec, j == 4, j >= 4, j < 4);
      end
    end
  endtask

  task automatic test_clear_done();
    send(CMD_CLEAR, 0, 1'b0, 0);
    checks++;
    if ({count, tick, done, busy} !== 11'd0) begin
      failures++;
      $display("FAIL clear_done: count=%0d tick=%0b done=%0b busy=%0b required all 0",
               count, tick, done, busy);
    end
  endtask

  task automatic test_periodic(input int t, input int p);
    int pe;
    int len;
    logic [7:0] ec;
    logic et;
    pe = PS_ON ? p : 0;
    len = (t + 1) * (pe + 1);
    send(CMD_START, t, 1'b1, p);
    for (int j = 1; j <= 3 * len; j++) begin
      step();
      ec = 8'((j / (pe + 1)) % (t + 1));
      et = (j % len) == 0;
      checks++;
      if ({count, tick, busy, done} !== {ec, et, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL periodic t=%0d p=%0d j=%0d: count=%0d tick=%0b busy=%0b done=%0b required count=%0d tick=%0b busy=1 done=0",
                 t, p, j, count, tick, busy, done, ec, et);
      end
    end
    send(CMD_CLEAR, 0, 1'b0, 0);
    checks++;
    if ({count, busy, done} !== 10'd0) begin
      failures++;
      $display("FAIL periodic_clear: count=%0d busy=%0b done=%0b required all 0",
               count, busy, done);
    end
  endtask

  task automatic test_pause();
    logic [7:0] ec;
    send(CMD_START, 4, 1'b1, 0);
    step();
    step();
    send(CMD_STOP, 0, 1'b0, 0);
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) step();
      checks++;
      if ({count, tick, busy, done} !== {8'd2, 3'b000}) begin
        failures++;
        $display("FAIL pause_hold j=%0d: count=%0d tick=%0b busy=%0b done=%0b required count=2 tick=0 busy=0 done=0",
                 j, count, tick, busy, done);
      end
    end
    send(CMD_START, 0, 1'b0, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      ec = (k < 3) ? 8'(k + 2) : 8'd0;
      checks++;
      if ({count, tick, busy} !== {ec, k == 3, 1'b1}) begin
        failures++;
        $display("FAIL pause_resume k=%0d: count=%0d tick=%0b busy=%0b required count=%0d tick=%0b busy=1",
                 k, count, tick, busy, ec, k == 3);
      end
    end
    send(CMD_CLEAR, 0, 1'b0, 0);
  endtask

  task automatic test_stop_terminal();
    send(CMD_START, 2, 1'b0, 0);
    step();
    step();
    checks++;
    if (count !== 8'd2) begin
      failures++;
      $display("FAIL stopterm_pre: count=%0d required 2", count);
    end
    send(CMD_STOP, 0, 1'b0, 0);
    for (int j = 0; j < 2; j++) begin
      if (j > 0) step();
      checks++;
      if ({count, tick, busy, done} !== {8'd2, 3'b000}) begin
        failures++;
        $display("FAIL stopterm j=%0d: count=%0d tick=%0b busy=%0b done=%0b required count=2 tick=0 busy=0 done=0",
                 j, count, tick, busy, done);
      end
    end
    send(CMD_START, 0, 1'b0, 0);
    checks++;
    if ({count, tick, busy, done} !== {8'd2, 3'b010}) begin
      failures++;
      $display("FAIL stopterm_resume: count=%0d tick=%0b busy=%0b done=%0b required count=2 tick=0 busy=1 done=0",
               count, tick, busy, done);
    end
    step();
    checks++;
    if ({count, tick, busy, done} !== {8'd2, 3'b101}) begin
      failures++;
      $display("FAIL stopterm_done: count=%0d tick=%0b busy=%0b done=%0b required count=2 tick=1 busy=0 done=1",
               count, tick, busy, done);
    end
  endtask

  task automatic test_random();
    logic [11:0] act;
    logic [11:0] exp;
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      cmd_valid = ($urandom_range(0, 4) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      period    = 8'($urandom_range(0, 6));
      periodic  = 1'($urandom_range(0, 1));
      prescale  = 8'($urandom_range(0, 3));
      step();
      act = {count, tick, done, busy, cmd_ready};
      exp = {8'(m_cnt), m_tick, m_st == 3, m_st == 1, m_rdy};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL random i=%0d: count=%0d tick=%0b done=%0b busy=%0b rdy=%0b required count=%0d tick=%0b done=%0b busy=%0b rdy=%0b",
                 i, act[11:4], act[3], act[2], act[1], act[0],
                 exp[11:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
    rst_n = 1'b1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_clear_done();
    test_periodic(2, 1);
    test_periodic(1, 5);
    test_periodic(0, 0);
    test_periodic(255, 0);
    test_pause();
    test_stop_terminal();
    test_clear_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Controller that sequences a free-running binary count into a programmable interval timer: accepts start/stop/clear commands over a valid/ready handshake, generates the count enable through an optional prescaler, and compares the count against a programmed terminal value. It produces one-shot or periodic tick pulses. It sits between the register/command interface and any logic needing timed events: PWM, debouncers and periodic sampling.

## Interface
- WIDTH, 8, width of count and period
- PRESCALE_W, 8, width of prescale divider
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 NOP, 01 START, 10 STOP, 11 CLEAR
- period  in  WIDTH  terminal count T; latched on START from IDLE/DONE
- periodic  in  1  1 = auto-reload, 0 = one-shot; latched with period
- prescale  in  PRESCALE_W  divider P; enable every P+1 cycles; latched with period
- count  out  WIDTH  current count
- busy  out  1  high in RUN
- tick  out  1  one-cycle pulse at terminal count
- done  out  1  level, high in DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (rst_n low at an edge): IDLE, count=0, tick=0, done=0, busy=0, cmd_ready=0; cmd_ready=1 from the first cycle after rst_n high. Reset mid-RUN aborts with no tick.
- cmd_ready drops for exactly one cycle after each accepted command, then returns to 1. NOP is accepted and has no effect.
- START in IDLE/DONE: latch T, periodic, P; count=0; prescaler cleared; go to RUN.
- START in PAUSE: resume RUN with latched config; count and prescaler phase are kept.
- START in RUN: ignored (accepted, no effect).
- STOP in RUN: go to PAUSE; count and prescaler are held. In other states STOP has no effect.
- CLEAR in any state: go to IDLE, count=0, done=0.
- RUN, on enable:
  - If count != T: count+1.
  - If count == T: tick=1. If periodic, count=0 and stay in RUN. If one-shot, count holds T and state goes to DONE.
- T=0: every enable is terminal.
- Count never exceeds T. Width wrap is impossible because T ≤ 2^WIDTH−1.
- Simultaneous events: a command accepted in a RUN cycle suppresses that cycle's enable. No count change and no tick occur; the command's transition is applied.

## Timing
- START accepted at edge N with P and T:
  - Increments occur at edges N+k(P+1), for k ≥ 1.
  - First tick and, in one-shot mode, done, are registered at edge N+(T+1)(P+1).
  - The periodic tick interval is exactly (T+1)(P+1) cycles.
- tick is registered and high for exactly one cycle, coincident with the updated count (0 or T).
- busy, done and count are registered and track state with zero extra latency.
- A pause of M cycles delays subsequent ticks by M+2 cycles: the STOP cycle and the START cycle both suppress an enable.

## Configuration
- TIMER_PRESCALER_EN defined: timer_prescaler is instantiated. The enable fires every P+1 RUN cycles as above.
- TIMER_PRESCALER_EN undefined: the prescaler is not built. The prescale port remains present but is ignored. The enable is 1 on every RUN cycle, so P is effectively 0 and the tick interval is T+1.

## Structure
- Shared package timer_pkg holds:
  - the state enum: IDLE, RUN, PAUSE, DONE
  - the cmd_op encodings CMD_NOP, CMD_START, CMD_STOP, CMD_CLEAR
- Sub-module timer_prescaler:
  - PRESCALE_W down-counter with clear, hold and load inputs
  - outputs a one-cycle enable
  - same clk/rst_n
- FSM, handshake and compare logic live in interval_timer_ctrl.

## Test plan
- Reset is low for 3 cycles, then released → all outputs are 0; cmd_ready=1 on the first cycle after release.
- START, T=3, P=0, one-shot → count 1,2,3 on successive edges; tick and done at edge N+4; count holds 3; busy=0.
- START, T=2, P=1, periodic → ticks every 6 cycles, at N+6, N+12 and N+18; count sequence 0,0,1,1,2,2,0…
- Periodic T=4, P=0, STOP at count 2, wait 5 cycles, START → count stays 2 while paused. Next tick arrives 7 cycles later than in an uninterrupted run.
- STOP issued exactly on the terminal-enable cycle → no tick; state PAUSE; count unchanged. CLEAR from DONE → IDLE, count 0, done 0.
- Build without TIMER_PRESCALER_EN, with P=5, T=1 → tick every 2 cycles.
